inst_sequencer: RTL and testbench

//  Upstream controller for core: replaces hand-driven stimulus by emitting the 34-bit inst word.
//  One kij pass runs five phases:
//   1. SRAM weights -> ififo
//   2. ififo -> PE load
//   3. SRAM activations -> L0
//   4. execute
//   5. ofifo -> psum SRAM

---
 rtl/inst_sequencer_pkg.sv | 64 ++++++
 rtl/inst_sequencer_if.sv | 14 +
 rtl/inst_sequencer_seq_phase_cnt.sv | 38 +++
 rtl/inst_sequencer.sv | 144 ++++++++++++++
 tb/tb_inst_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: core inst bit map, idle word,
// phase lengths and FSM state encoding.
package inst_sequencer_pkg;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int LEN_NIJ = 36;
  localparam int LEN_KIJ = 9;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 7;
  localparam int KIJ_W  = 4;

  localparam logic [ADDR_W-1:0] W_BASE = 11'd1024;

  // Core inst bit positions, MSB to LSB
  localparam int ACC        = 33;
  localparam int CEN_PMEM   = 32;
  localparam int WEN_PMEM   = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM   = 19;
  localparam int WEN_XMEM   = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD   = 6;
  localparam int IFIFO_WR   = 5;
  localparam int IFIFO_RD   = 4;
  localparam int L0_RD      = 3;
  localparam int L0_WR      = 2;
  localparam int EXECUTE    = 1;
  localparam int LOAD       = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFIFO  = 3'd1,
    S_WLOAD  = 3'd2,
    S_WDRAIN = 3'd3,
    S_XL0    = 3'd4,
    S_EXEC   = 3'd5,
    S_OFIFO  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    case (s)
      S_WFIFO:  return CNT_W'(COL);
      S_WLOAD:  return CNT_W'(COL);
      S_WDRAIN: return CNT_W'(COL + 10);
      S_XL0:    return CNT_W'(LEN_NIJ + 1);
      S_EXEC:   return CNT_W'(LEN_NIJ + ROW + COL);
      S_OFIFO:  return CNT_W'(LEN_NIJ);
      default:  return 7'd1;
    endcase
  endfunction

  // Largest value is 8*36+35 = 323, so 11 bits never wrap
  function automatic logic [ADDR_W-1:0] pmem_addr(input logic [KIJ_W-1:0] kij,
                                                  input logic [CNT_W-1:0] cnt);
    return ({7'd0, kij} * ADDR_W'(LEN_NIJ)) + {4'd0, cnt};
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Handshake bundle between a host controller (master) and the instruction sequencer (slave).
interface inst_sequencer_if;
  import inst_sequencer_pkg::*;

  logic              start;
  logic [KIJ_W-1:0]  kij;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (output start, kij, ofifo_valid, input inst, busy, done);
  modport slave  (input start, kij, ofifo_valid, output inst, busy, done);
endinterface

// File: rtl/inst_sequencer_seq_phase_cnt.sv
// seq_phase_cnt: clearable phase counter flagging the final enabled cycle of a phase.
module seq_phase_cnt
  import inst_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 7'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = en && (cnt_q == (limit - 7'd1));

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: walks one kij pass (weights, PE load, activations, execute, psum store)
// emitting the registered 34-bit core inst. Macro INST_SEQ_AUTO_KIJ_EN chains all kij passes.
module inst_sequencer
  import inst_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  inst_sequencer_if.slave   bus
);

  state_e            state_q, state_d;
  logic [KIJ_W-1:0]  kij_q, kij_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_en, cnt_clr, cnt_last;
  logic [CNT_W-1:0]  cnt, phase_limit;
  logic [ADDR_W-1:0] w_base;

  assign phase_limit = phase_len(state_q);
  assign cnt_clr     = (state_d != state_q) || (state_q == S_IDLE);

  seq_phase_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (phase_limit),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WFIFO;
`ifdef INST_SEQ_AUTO_KIJ_EN
          kij_d = 4'd0;
`else
          kij_d = (bus.kij >= KIJ_W'(LEN_KIJ)) ? KIJ_W'(LEN_KIJ - 1) : bus.kij;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WFIFO, S_WLOAD, S_WDRAIN, S_XL0, S_EXEC: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = state_e'(state_q + 3'd1);
        end else begin
          state_d = state_q;
        end
      end
      S_OFIFO: begin
        // Only beats advance the counter; an empty ofifo stalls indefinitely
        cnt_en = bus.ofifo_valid;
        if (cnt_last) begin
`ifdef INST_SEQ_AUTO_KIJ_EN
          if (kij_q == KIJ_W'(LEN_KIJ - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WFIFO;
            kij_d   = kij_q + 4'd1;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_OFIFO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d = IDLE_INST;
`ifdef INST_SEQ_AUTO_KIJ_EN
    w_base = W_BASE + ({7'd0, kij_q} * ADDR_W'(COL));
`else
    w_base = W_BASE;
`endif
    case (state_q)
      S_WFIFO: begin
        inst_d[CEN_XMEM]                 = 1'b0;
        inst_d[A_XMEM_LSB +: ADDR_W]     = w_base + {4'd0, cnt};
        inst_d[IFIFO_WR]                 = 1'b1;
      end
      S_WLOAD: begin
        inst_d[IFIFO_RD] = 1'b1;
        inst_d[LOAD]     = 1'b1;
      end
      S_WDRAIN: inst_d[LOAD] = 1'b1;
      S_XL0: begin
        inst_d[CEN_XMEM]             = 1'b0;
        inst_d[A_XMEM_LSB +: ADDR_W] = {4'd0, cnt};
        inst_d[L0_WR]                = 1'b1;
      end
      S_EXEC: begin
        inst_d[L0_RD]   = 1'b1;
        inst_d[EXECUTE] = 1'b1;
      end
      S_OFIFO: begin
        inst_d[A_PMEM_LSB +: ADDR_W] = pmem_addr(kij_q, cnt);
        if (bus.ofifo_valid) begin
          inst_d[OFIFO_RD] = 1'b1;
          inst_d[CEN_PMEM] = 1'b0;
          inst_d[WEN_PMEM] = 1'b0;
        end else begin
          inst_d[OFIFO_RD] = 1'b0;
        end
      end
      default: inst_d = IDLE_INST;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kij_q   <= '0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer; pass INST_SEQ_AUTO_KIJ_EN to exercise the chained-kij build.
module tb_inst_sequencer;

  logic clk = 1'b0;
  logic reset;
  inst_sequencer_if bus();

  inst_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  int n_cmp = 0;
  int n_bad = 0;

  int n_ififo_wr, n_ififo_rd, n_load, n_l0_wr, n_l0_rd, n_exec, n_pmem, n_done, done_k;
  int xw_bad, xl_bad, pm_bad, stall_bad, acc_seen, busy_bad, last_pmem;
  logic [33:0] inst_k0, inst_k1;
  logic        busy_k0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one start and gathers per-field statistics; stops 20 cycles after done or at budget
  task automatic run_pass(input logic [3:0] kij_in, input int pm_start, input bit toggle_valid,
                          input bit pulse, input int budget);
    int pm_expect;
    logic [33:0] w;
    logic v;
    n_ififo_wr = 0; n_ififo_rd = 0; n_load = 0; n_l0_wr = 0; n_l0_rd = 0; n_exec = 0;
    n_pmem = 0; n_done = 0; done_k = -1; xw_bad = 0; xl_bad = 0; pm_bad = 0;
    stall_bad = 0; acc_seen = 0; busy_bad = 0; last_pmem = -1;
    pm_expect = pm_start;
    bus.kij = kij_in; bus.start = 1'b1; bus.ofifo_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    inst_k0 = bus.inst;
    busy_k0 = bus.busy;
    inst_k1 = '0;
    for (int k = 1; k <= budget; k++) begin
      v = toggle_valid ? (((k % 4) == 1) || ((k % 4) == 0)) : 1'b1;
      bus.ofifo_valid = v;
      if (pulse && (k == 11 || k == 160)) begin
        bus.start = 1'b1;
        bus.kij   = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      w = bus.inst;
      if (k == 1) inst_k1 = w;
      if (w[33]) acc_seen++;
      if (w[5]) begin
        if (w[19] || !w[18] || (w[17:7] != 11'(1024 + n_ififo_wr))) xw_bad++;
        n_ififo_wr++;
      end
      if (w[4]) n_ififo_rd++;
      if (w[0]) n_load++;
      if (w[2]) begin
        if (w[19] || (w[17:7] != 11'(n_l0_wr % 37))) xl_bad++;
        n_l0_wr++;
      end
      if (w[3]) n_l0_rd++;
      if (w[1]) n_exec++;
      if (!w[32] && !w[31]) begin
        if (!v || !w[6]) stall_bad++;
        if (w[30:20] != 11'(pm_expect)) pm_bad++;
        pm_expect++;
        n_pmem++;
        last_pmem = int'(w[30:20]);
      end else if (w[6]) begin
        stall_bad++;
      end
      if (bus.done) begin
        n_done++;
        if (done_k < 0) done_k = k;
        if (bus.busy) busy_bad++;
      end else if (done_k < 0 && !bus.busy) begin
        busy_bad++;
      end
      if (done_k >= 0 && k > done_k && (bus.busy || bus.inst !== IDLE_W)) busy_bad++;
      if (done_k >= 0 && k >= done_k + 20) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.kij = 4'd0; bus.ofifo_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bus.inst !== IDLE_W) begin n_bad++; $display("FAIL reset_inst: got %h want %h", bus.inst, IDLE_W); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    bus.start = 1'b1; bus.kij = 4'd3;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.inst !== IDLE_W) begin n_bad++; $display("FAIL reset_wins_start: busy %b inst %h want 0 %h", bus.busy, bus.inst, IDLE_W); end
  endtask

  task automatic test_reset_mid_exec();
    int seen, wait_n, stray;
    seen = 0; stray = 0;
    bus.kij = 4'd0; bus.ofifo_valid = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (wait_n = 0; wait_n < 200 && seen == 0; wait_n++) begin
      tick();
      if (bus.inst[1]) seen = 1;
    end
    n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL exec_reached: got %0d want 1", seen); end
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.inst !== IDLE_W) begin n_bad++; $display("FAIL mid_reset_inst: got %h want %h", bus.inst, IDLE_W); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.inst !== IDLE_W || bus.busy || bus.done) stray++;
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_single_pass();
    run_pass(4'd2, 72, 1'b0, 1'b0, 400);
    n_cmp++; if (inst_k0 !== IDLE_W) begin n_bad++; $display("FAIL accept_inst: got %h want %h", inst_k0, IDLE_W); end
    n_cmp++; if (busy_k0 !== 1'b1) begin n_bad++; $display("FAIL accept_busy: got %b want 1", busy_k0); end
    n_cmp++; if (inst_k1 !== 34'h1_8006_0020) begin n_bad++; $display("FAIL first_wfifo_inst: got %h want 180060020", inst_k1); end
    n_cmp++; if (n_ififo_wr != 8 || xw_bad != 0) begin n_bad++; $display("FAIL ififo_wr: got %0d (bad %0d) want 8 (bad 0)", n_ififo_wr, xw_bad); end
    n_cmp++; if (n_load != 26 || n_ififo_rd != 8) begin n_bad++; $display("FAIL load: got load %0d rd %0d want 26 8", n_load, n_ififo_rd); end
    n_cmp++; if (n_l0_wr != 37 || xl_bad != 0) begin n_bad++; $display("FAIL l0_wr: got %0d (bad %0d) want 37 (bad 0)", n_l0_wr, xl_bad); end
    n_cmp++; if (n_exec != 52 || n_l0_rd != 52) begin n_bad++; $display("FAIL execute: got exec %0d l0_rd %0d want 52 52", n_exec, n_l0_rd); end
    n_cmp++; if (n_pmem != 36 || pm_bad != 0 || last_pmem != 107) begin n_bad++; $display("FAIL pmem: got n %0d bad %0d last %0d want 36 0 107", n_pmem, pm_bad, last_pmem); end
    n_cmp++; if (n_done != 1 || done_k != 160) begin n_bad++; $display("FAIL done: got n %0d at %0d want 1 at 160", n_done, done_k); end
    n_cmp++; if (busy_bad != 0 || acc_seen != 0 || stall_bad != 0) begin n_bad++; $display("FAIL pass_misc: got busy %0d acc %0d rd %0d want 0 0 0", busy_bad, acc_seen, stall_bad); end
  endtask

  task automatic test_ofifo_stall();
    run_pass(4'd2, 72, 1'b1, 1'b0, 600);
    n_cmp++; if (n_pmem != 36 || pm_bad != 0 || last_pmem != 107) begin n_bad++; $display("FAIL stall_pmem: got n %0d bad %0d last %0d want 36 0 107", n_pmem, pm_bad, last_pmem); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_gating: got %0d want 0", stall_bad); end
    n_cmp++; if (n_done != 1 || done_k != 194) begin n_bad++; $display("FAIL stall_done: got n %0d at %0d want 1 at 194", n_done, done_k); end
  endtask

  task automatic test_start_ignored();
    run_pass(4'd2, 72, 1'b0, 1'b1, 400);
    n_cmp++; if (n_done != 1 || done_k != 160) begin n_bad++; $display("FAIL ignored_done: got n %0d at %0d want 1 at 160", n_done, done_k); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL ignored_busy: got %0d want 0", busy_bad); end
    n_cmp++; if (n_pmem != 36 || pm_bad != 0) begin n_bad++; $display("FAIL ignored_kij: got n %0d bad %0d want 36 0", n_pmem, pm_bad); end
  endtask

  task automatic test_kij_clamp();
    run_pass(4'd12, 288, 1'b0, 1'b0, 400);
    n_cmp++; if (n_pmem != 36 || pm_bad != 0 || last_pmem != 323) begin n_bad++; $display("FAIL clamp_pmem: got n %0d bad %0d last %0d want 36 0 323", n_pmem, pm_bad, last_pmem); end
  endtask

  task automatic test_auto_kij();
    run_pass(4'd7, 0, 1'b0, 1'b0, 3000);
    n_cmp++; if (n_ififo_wr != 72 || xw_bad != 0) begin n_bad++; $display("FAIL auto_weights: got %0d (bad %0d) want 72 (bad 0)", n_ififo_wr, xw_bad); end
    n_cmp++; if (n_l0_wr != 333 || xl_bad != 0) begin n_bad++; $display("FAIL auto_l0: got %0d (bad %0d) want 333 (bad 0)", n_l0_wr, xl_bad); end
    n_cmp++; if (n_exec != 468) begin n_bad++; $display("FAIL auto_exec: got %0d want 468", n_exec); end
    n_cmp++; if (n_pmem != 324 || pm_bad != 0 || last_pmem != 323) begin n_bad++; $display("FAIL auto_pmem: got n %0d bad %0d last %0d want 324 0 323", n_pmem, pm_bad, last_pmem); end
    n_cmp++; if (n_done != 1 || done_k != 1432) begin n_bad++; $display("FAIL auto_done: got n %0d at %0d want 1 at 1432", n_done, done_k); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL auto_busy: got %0d want 0", busy_bad); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
`ifdef INST_SEQ_AUTO_KIJ_EN
    test_auto_kij();
`else
    test_single_pass();
    test_ofifo_stall();
    test_start_ignored();
    test_kij_clamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
